inport_fifo: RTL and testbench

Buffered input port feeding the CPU bus multiplexer's InPort source. An external device pushes 32-bit words through a valid/ready handshake into a small FIFO. The head word is presented on `InPort_Data` for the bus mux. It is consumed when the control unit's `InPort_Out` strobe ends, so the `in Ra` instruction reads a stable word for as long as the strobe is held.

---
 rtl/inport_fifo.sv | 146 ++++++++++++++
 tb/tb_inport_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/inport_fifo.sv
// rtl/inport_fifo.sv - buffered input port FIFO feeding the bus mux InPort source
//
// Optional feature macro: INPORT_HOLD_EN
//   defined   : a hold register keeps the last popped word on InPort_Data while empty
//   undefined : InPort_Data is 0 while empty
//
// Ports:
//   Clock        system clock, rising edge
//   Clear        asynchronous active-low reset
//   Ext_Data     word from the external device
//   Ext_Valid    external word valid
//   Ext_Ready    FIFO can accept a word (count != DEPTH)
//   InPort_Out   control strobe, bus is reading the input port
//   InPort_Data  head word to the bus mux
//   Data_Avail   FIFO not empty
//   Count        number of occupied entries
//   Underflow    sticky, a read completed while empty

module inport_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       Clear,
    input  logic [WIDTH-1:0]           Ext_Data,
    input  logic                       Ext_Valid,
    output logic                       Ext_Ready,
    input  logic                       InPort_Out,
    output logic [WIDTH-1:0]           InPort_Data,
    output logic                       Data_Avail,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             strobe_q, strobe_d;     // InPort_Out from the previous cycle
    logic             underflow_q, underflow_d;

    logic             not_full;
    logic             not_empty;
    logic             rd_complete;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head_word;

    assign not_full    = (count_q != CNT_FULL);
    assign not_empty   = (count_q != CNT_ZERO);
    // The bus reads for as long as the strobe is held; the word is consumed
    // only when the strobe falls.
    assign rd_complete = strobe_q && !InPort_Out;
    assign push        = Ext_Valid && not_full;
    assign pop         = rd_complete && not_empty;
    assign head_word   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        strobe_d    = InPort_Out;
        underflow_d = underflow_q;

        if (push) begin
            mem_d[wr_ptr_q] = Ext_Data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (rd_complete && !not_empty) begin
            underflow_d = 1'b1;
        end

        // A pop from empty is an underflow, not a pop, so a concurrent push
        // still raises the count from 0 to 1.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            strobe_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            strobe_q    <= strobe_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array carries no reset; unread entries are never observed.
    always_ff @(posedge Clock) begin
        mem_q <= mem_d;
    end

`ifdef INPORT_HOLD_EN
    logic [WIDTH-1:0] hold_q, hold_d;

    always_comb begin
        hold_d = hold_q;
        if (pop) begin
            hold_d = head_word;
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign InPort_Data = not_empty ? head_word : hold_q;
`else
    assign InPort_Data = not_empty ? head_word : '0;
`endif

    assign Ext_Ready  = not_full;
    assign Data_Avail = not_empty;
    assign Count      = count_q;
    assign Underflow  = underflow_q;

endmodule

// File: tb/tb_inport_fifo.sv
// tb/tb_inport_fifo.sv - self-checking bench for inport_fifo against a queue model

module tb_inport_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             Clock;
    logic             Clear;
    logic [WIDTH-1:0] Ext_Data;
    logic             Ext_Valid;
    logic             Ext_Ready;
    logic             InPort_Out;
    logic [WIDTH-1:0] InPort_Data;
    logic             Data_Avail;
    logic [2:0]       Count;
    logic             Underflow;

    inport_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clock       (Clock),
        .Clear       (Clear),
        .Ext_Data    (Ext_Data),
        .Ext_Valid   (Ext_Valid),
        .Ext_Ready   (Ext_Ready),
        .InPort_Out  (InPort_Out),
        .InPort_Data (InPort_Data),
        .Data_Avail  (Data_Avail),
        .Count       (Count),
        .Underflow   (Underflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of words plus the few scalars the rules mention.
    logic [WIDTH-1:0] q[$];
    logic             m_strobe_prev;
    logic             m_underflow;
    logic [WIDTH-1:0] m_last_popped;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_data();
        if (q.size() > 0) return q[0];
`ifdef INPORT_HOLD_EN
        return m_last_popped;
`else
        return '0;
`endif
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".count"},     64'(Count),       64'(q.size()));
        check({tag, ".ready"},     64'(Ext_Ready),   64'(q.size() != DEPTH));
        check({tag, ".avail"},     64'(Data_Avail),  64'(q.size() != 0));
        check({tag, ".data"},      64'(InPort_Data), 64'(model_data()));
        check({tag, ".underflow"}, 64'(Underflow),   64'(m_underflow));
    endtask

    function automatic void model_reset();
        q.delete();
        m_strobe_prev = 1'b0;
        m_underflow   = 1'b0;
        m_last_popped = '0;
    endfunction

    // One rising edge: advance the model from the inputs sampled at that edge,
    // then compare shortly after.
    task automatic step(input string tag);
        bit will_push;
        bit read_done;
        @(posedge Clock);
        will_push = Ext_Valid && (q.size() != DEPTH);
        read_done = m_strobe_prev && !InPort_Out;
        if (read_done) begin
            if (q.size() > 0) m_last_popped = q.pop_front();
            else              m_underflow   = 1'b1;
        end
        if (will_push) q.push_back(Ext_Data);
        m_strobe_prev = InPort_Out;
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between rising edges.
    task automatic pulse_reset(input string tag, input bit drop_strobe);
        @(negedge Clock);
        Clear = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".in_reset"});
        #1;
        Ext_Valid = 1'b0;
        if (drop_strobe) InPort_Out = 1'b0;
        Clear = 1'b1;
        #1;
        check_all({tag, ".released"});
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        Ext_Valid = 1'b1;
        Ext_Data  = w;
        step("push");
        Ext_Valid = 1'b0;
    endtask

    task automatic read_strobe(input int k, input logic [WIDTH-1:0] exp_head);
        InPort_Out = 1'b1;
        for (int i = 0; i < k; i++) begin
            step("strobe_hi");
            check("strobe_head", 64'(InPort_Data), 64'(exp_head));
        end
        InPort_Out = 1'b0;
        step("strobe_lo");
    endtask

    initial begin
        Clear      = 1'b0;
        Ext_Data   = '0;
        Ext_Valid  = 1'b0;
        InPort_Out = 1'b0;
        model_reset();
        #12;
        check_all("por");
        Clear = 1'b1;

        // Reset values with count=3
        push_word(32'h11);
        push_word(32'h12);
        push_word(32'h13);
        check("pre_reset_count", 64'(Count), 64'd3);
        pulse_reset("reset_mid", 1'b0);
        check("reset_count", 64'(Count), 64'd0);
        check("reset_data", 64'(InPort_Data), 64'd0);

        // Single push and read
        push_word(32'h55);
        read_strobe(2, 32'h55);
        check("single_count", 64'(Count), 64'd0);
`ifdef INPORT_HOLD_EN
        check("single_empty_data", 64'(InPort_Data), 64'h55);
`else
        check("single_empty_data", 64'(InPort_Data), 64'h0);
`endif

        // Fill, refused push, refill across pointer wrap
        pulse_reset("fill", 1'b0);
        push_word(32'hA1);
        push_word(32'hA2);
        push_word(32'hA3);
        push_word(32'hA4);
        check("full_ready", 64'(Ext_Ready), 64'd0);
        push_word(32'hA5);
        check("full_count", 64'(Count), 64'd4);
        check("full_head", 64'(InPort_Data), 64'hA1);
        read_strobe(1, 32'hA1);
        check("after_pop_ready", 64'(Ext_Ready), 64'd1);
        push_word(32'hA5);
        read_strobe(1, 32'hA2);
        read_strobe(3, 32'hA3);
        read_strobe(1, 32'hA4);
        read_strobe(2, 32'hA5);
        check("wrap_count", 64'(Count), 64'd0);

        // Simultaneous push and pop
        pulse_reset("simul", 1'b0);
        push_word(32'hB1);
        push_word(32'hB2);
        InPort_Out = 1'b1;
        step("simul_hi");
        InPort_Out = 1'b0;
        Ext_Valid  = 1'b1;
        Ext_Data   = 32'hB3;
        step("simul_lo");
        Ext_Valid  = 1'b0;
        check("simul_count", 64'(Count), 64'd2);
        check("simul_head", 64'(InPort_Data), 64'hB2);

        // Underflow with concurrent push
        pulse_reset("uflow", 1'b0);
        InPort_Out = 1'b1;
        step("uflow_hi");
        InPort_Out = 1'b0;
        Ext_Valid  = 1'b1;
        Ext_Data   = 32'hC0;
        step("uflow_lo");
        Ext_Valid  = 1'b0;
        check("uflow_flag", 64'(Underflow), 64'd1);
        check("uflow_count", 64'(Count), 64'd1);
        check("uflow_head", 64'(InPort_Data), 64'hC0);
        read_strobe(1, 32'hC0);
        repeat (3) step("uflow_idle");
        check("uflow_sticky", 64'(Underflow), 64'd1);
        pulse_reset("uflow_clr", 1'b0);
        check("uflow_cleared", 64'(Underflow), 64'd0);

        // Reset while strobe is high, strobe dropped before any edge sees it
        InPort_Out = 1'b1;
        step("mid_strobe_hi");
        pulse_reset("mid_strobe", 1'b1);
        step("mid_strobe_lo");
        check("mid_strobe_uflow", 64'(Underflow), 64'd0);
        check("mid_strobe_count", 64'(Count), 64'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            Ext_Valid  = ($urandom_range(0, 99) < 55);
            Ext_Data   = $urandom;
            InPort_Out = ($urandom_range(0, 99) < 45);
            step("rand");
            if ($urandom_range(0, 999) == 0) pulse_reset("rand_rst", 1'b0);
        end
        Ext_Valid  = 1'b0;
        InPort_Out = 1'b0;
        step("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
